regfile_param: RTL and testbench
================================

# regfile_param

Parametrised general-purpose register file for the single-cycle and multi-cycle MIPS datapaths. It has two asynchronous read ports and one falling-edge write port with byte enables. A hardware clear sequencer zeroes the array one entry per cycle on request. It replaces the fixed 32x32 register file and sits between the decode stage (read addresses) and the write-back mux (write data).

## Interface
Parameters:
- DW, 32, data width in bits; must be a multiple of 8
- AW, 5, address width; DEPTH = 2**AW entries
- ZERO_REG, 1, 1 = entry 0 hardwired to zero; 0 = entry 0 is an ordinary register

Ports:
- CLK  in  1  clock; all state updates on the falling edge
- RST  in  1  reset, asynchronous, active-high
- R_Addr_A  in  AW  read port A address
- R_Addr_B  in  AW  read port B address
- R_Data_A  out  DW  read port A data, combinational
- R_Data_B  out  DW  read port B data, combinational
- W_Addr  in  AW  write address
- W_Data  in  DW  write data
- W_BE  in  DW/8  byte enables; bit i covers W_Data[8i+7:8i]
- Write_Reg  in  1  write strobe
- CLR_Req  in  1  start a clear sweep
- Busy  out  1  clear sweep in progress
- W_Drop  out  1  one-cycle pulse: a write was discarded

## Operation
- Reads: R_Data_X = REG[R_Addr_X]. If ZERO_REG=1 and R_Addr_X==0, R_Data_X = 0.
- Write commit conditions, evaluated at the falling edge:
  - Write_Reg=1
  - Busy=0
  - not (ZERO_REG=1 and W_Addr==0)
- On commit, only the bytes with W_BE[i]=1 are updated; other bytes hold.
- Write_Reg=1 with W_BE all zero is a legal no-op and does not pulse W_Drop.
- Write_Reg=1 while Busy=1: write discarded; W_Drop=1 for the following CLK period.
- Write_Reg=1 to entry 0 with ZERO_REG=1: silently ignored; W_Drop stays 0.
- Clear sequencer FSM has two states, IDLE and SWEEP, with index counter idx[AW-1:0]:
  - IDLE: CLR_Req=1 at a falling edge moves to SWEEP with idx=0 and Busy=1. The same edge performs any pending write normally.
  - SWEEP: each falling edge sets REG[idx]=0 and increments idx. The edge that clears idx=DEPTH-1 returns to IDLE with Busy=0 and idx wrapping to 0.
  - CLR_Req is ignored while in SWEEP; no restart and no queuing.
- Reads during SWEEP return current contents: already-cleared entries read 0, entries not yet cleared hold old values.
- RST=1, asynchronously:
  - all entries 0, state IDLE, idx=0
  - Busy=0, W_Drop=0
  - R_Data_A and R_Data_B read 0
- RST asserted mid-sweep aborts the sweep. Deassertion leaves the block in IDLE.

## Timing
- Read latency 0: outputs follow addresses and array state combinationally.
- Write latency: data is visible on the read ports immediately after the committing falling edge, so it is readable at the next rising edge.
- Sweep duration: exactly DEPTH falling edges (32 at the defaults). Busy is high for DEPTH CLK periods, starting at the edge that samples CLR_Req.
- W_Drop is registered at the falling edge and is high for exactly one CLK period per dropped write. Consecutive drops keep it high continuously.
- Sweep clear and external write never hit the same edge, because writes are blocked in SWEEP. A write coinciding with CLR_Req in IDLE commits first; the sweep later clears that entry.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: each read port forwards in the same cycle.
  - If Write_Reg=1, Busy=0, R_Addr_X==W_Addr, and the address is writable, R_Data_X returns W_Data for the bytes with W_BE=1 and the stored bytes for the rest, before the write edge.
  - ZERO_REG masking still applies.
- Not defined: reads return only the stored array content, and new data appears only after the falling edge.

## Test plan
- Reset, then read every address on both ports -> all reads 0; Busy=0; W_Drop=0.
- Write 0xDEADBEEF to addr 5 with W_BE=4'b1111, then write 0x000000AA to addr 5 with W_BE=4'b0001 -> R_Data_A at addr 5 reads 0xDEADBEAA. Write 0x12345678 to addr 0 with ZERO_REG=1 -> reads 0; W_Drop=0.
- Fill addrs 1..31 with value=addr, pulse CLR_Req -> Busy high for 32 cycles. After k edges, addr k-1 reads 0 and addr k still reads k. After the sweep, all entries read 0 and Busy=0.
- During a sweep, assert Write_Reg to addr 3 with 0x55 -> W_Drop high for one cycle. After the sweep, addr 3 reads 0.
- Start a sweep, assert RST at sweep cycle 10 -> all entries 0, Busy=0 immediately. After RST release, a write of 0x77 to addr 2 commits normally.
- With REGFILE_BYPASS_EN defined: W_Addr=R_Addr_B=7, W_Data=0x11223344, W_BE=4'b0011, old value 0xAABBCCDD -> R_Data_B=0xAABB3344 before the edge and the same value after. Without the macro, R_Data_B=0xAABBCCDD before the edge.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file for the MIPS datapaths.
// Two combinational read ports, one byte-enabled write port that commits on the
// falling clock edge, and a clear sequencer that zeroes one entry per cycle.
// Optional feature: define REGFILE_BYPASS_EN to forward the pending write to
// matching read ports in the same cycle. Without it, reads see stored data only.
module regfile_param #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [AW-1:0]       R_Addr_A,
  input  logic [AW-1:0]       R_Addr_B,
  output logic [DW-1:0]       R_Data_A,
  output logic [DW-1:0]       R_Data_B,
  input  logic [AW-1:0]       W_Addr,
  input  logic [DW-1:0]       W_Data,
  input  logic [(DW/8)-1:0]   W_BE,
  input  logic                Write_Reg,
  input  logic                CLR_Req,
  output logic                Busy,
  output logic                W_Drop
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned NB    = DW / 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  logic [DW-1:0] mem [DEPTH];

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_nxt;
  logic          busy_nxt;
  logic          drop_nxt;

  logic          writable_c;
  logic          be_any_c;
  logic          wr_commit_c;
  logic          sweep_clr_c;
  logic [DW-1:0] wr_word_c;

  // Overlay the enabled bytes of the new data onto the old word.
  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_word,
                                                input logic [DW-1:0] new_word,
                                                input logic [NB-1:0] be);
    logic [DW-1:0] res;
    res = old_word;
    for (int b = 0; b < int'(NB); b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // Write qualification: entry 0 is read-only when hardwired to zero.
  always_comb begin
    writable_c = 1'b1;
    if ((ZERO_REG != 0) && (W_Addr == '0)) writable_c = 1'b0;
    be_any_c    = |W_BE;
    wr_commit_c = Write_Reg && !Busy && writable_c && be_any_c;
    sweep_clr_c = (state == ST_SWEEP);
    wr_word_c   = merge_bytes(mem[W_Addr], W_Data, W_BE);
  end

  // Clear sequencer next-state, busy and drop-pulse logic.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    busy_nxt  = 1'b0;
    drop_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (CLR_Req) begin
          state_nxt = ST_SWEEP;
          idx_nxt   = '0;
        end
      end
      ST_SWEEP: begin
        idx_nxt = AW'(idx + 1'b1);
        if (idx == '1) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
      end
    endcase
    busy_nxt = (state_nxt == ST_SWEEP);
    // Only a write that would otherwise have committed counts as dropped.
    drop_nxt = Write_Reg && Busy && writable_c && be_any_c;
  end

  // Sequencer state and registered status outputs.
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_IDLE;
      idx    <= '0;
      Busy   <= 1'b0;
      W_Drop <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      Busy   <= busy_nxt;
      W_Drop <= drop_nxt;
    end
  end

  // Storage array: sweep clear and external write are mutually exclusive.
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (sweep_clr_c) begin
      mem[idx] <= '0;
    end else if (wr_commit_c) begin
      mem[W_Addr] <= wr_word_c;
    end
  end

  // Read port A.
  always_comb begin
    R_Data_A = mem[R_Addr_A];
`ifdef REGFILE_BYPASS_EN
    if (wr_commit_c && (R_Addr_A == W_Addr)) R_Data_A = wr_word_c;
`endif
    if ((ZERO_REG != 0) && (R_Addr_A == '0)) R_Data_A = '0;
  end

  // Read port B.
  always_comb begin
    R_Data_B = mem[R_Addr_B];
`ifdef REGFILE_BYPASS_EN
    if (wr_commit_c && (R_Addr_B == W_Addr)) R_Data_B = wr_word_c;
`endif
    if ((ZERO_REG != 0) && (R_Addr_B == '0)) R_Data_B = '0;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Testbench for regfile_param: per-cycle scoreboard against an array model,
// plus fixed-value spot checks for the documented scenarios.
module tb_regfile_param;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned NB    = 4;

  logic          CLK;
  logic          RST;
  logic [AW-1:0] R_Addr_A;
  logic [AW-1:0] R_Addr_B;
  logic [DW-1:0] R_Data_A;
  logic [DW-1:0] R_Data_B;
  logic [AW-1:0] W_Addr;
  logic [DW-1:0] W_Data;
  logic [NB-1:0] W_BE;
  logic          Write_Reg;
  logic          CLR_Req;
  logic          Busy;
  logic          W_Drop;

  regfile_param #(.DW(DW), .AW(AW), .ZERO_REG(1)) dut (
    .CLK(CLK), .RST(RST),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .R_Data_A(R_Data_A), .R_Data_B(R_Data_B),
    .W_Addr(W_Addr), .W_Data(W_Data), .W_BE(W_BE),
    .Write_Reg(Write_Reg), .CLR_Req(CLR_Req),
    .Busy(Busy), .W_Drop(W_Drop)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state
  logic [DW-1:0] mdl [DEPTH];
  bit            m_busy;
  int            m_pos;
  bit            m_drop;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          busy;
    logic          drop;
  } exp_t;

  exp_t  q[$];
  string qn[$];
  int    errors = 0;
  int    checks = 0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < int'(NB); b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] expect_read(input logic [AW-1:0] addr);
    logic [DW-1:0] v;
    v = mdl[addr];
`ifdef REGFILE_BYPASS_EN
    if (Write_Reg && !m_busy && (addr == W_Addr) && (W_Addr != 0))
      v = merge(v, W_Data, W_BE);
`endif
    if (addr == 0) v = '0;
    return v;
  endfunction

  task automatic chk(input string nm, input string what,
                     input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s: got %h want %h", nm, what, got, want);
    end
  endtask

  // One clock period: drive at the rising edge, queue the expected
  // observation, then advance the model across the coming falling edge.
  task automatic step(input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                      input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic [NB-1:0] be,
                      input logic clr, input logic rst, input string nm);
    exp_t e;
    bit   allow;
    @(posedge CLK);
    R_Addr_A = ra; R_Addr_B = rb;
    Write_Reg = we; W_Addr = wa; W_Data = wd; W_BE = be;
    CLR_Req = clr; RST = rst;
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mdl[i] = '0;
      m_busy = 0; m_pos = 0; m_drop = 0;
    end
    e.a = expect_read(ra);
    e.b = expect_read(rb);
    e.busy = m_busy;
    e.drop = m_drop;
    q.push_back(e);
    qn.push_back(nm);
    if (!rst) begin
      allow  = we && (be != 0) && (wa != 0);
      m_drop = allow && m_busy;
      if (allow && !m_busy) mdl[wa] = merge(mdl[wa], wd, be);
      if (m_busy) begin
        mdl[m_pos] = '0;
        m_pos++;
        if (m_pos == int'(DEPTH)) begin
          m_busy = 0;
          m_pos  = 0;
        end
      end else if (clr) begin
        m_busy = 1;
        m_pos  = 0;
      end
    end
  endtask

  task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                      input string nm);
    step(ra, rb, 1'b0, '0, '0, '0, 1'b0, 1'b0, nm);
  endtask

  // Monitor: pops one expectation per cycle, after inputs have settled.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge CLK);
      #2;
      if (q.size() > 0) begin
        e  = q.pop_front();
        nm = qn.pop_front();
        chk(nm, "R_Data_A", R_Data_A, e.a);
        chk(nm, "R_Data_B", R_Data_B, e.b);
        chk(nm, "Busy", DW'(Busy), DW'(e.busy));
        chk(nm, "W_Drop", DW'(W_Drop), DW'(e.drop));
      end
    end
  end

  initial begin
    RST = 1'b1; R_Addr_A = '0; R_Addr_B = '0; W_Addr = '0; W_Data = '0;
    W_BE = '0; Write_Reg = 1'b0; CLR_Req = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) mdl[i] = '0;
    m_busy = 0; m_pos = 0; m_drop = 0;

    // Reset and read-back of every address
    step('0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b1, "reset");
    step('0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b1, "reset");
    for (int i = 0; i < int'(DEPTH); i++) idle(AW'(i), AW'(31 - i), "reset_read");

    // Full write, then byte-merge
    step(5, 5, 1'b1, 5, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0, "wr_full");
    step(5, 5, 1'b1, 5, 32'h000000AA, 4'b0001, 1'b0, 1'b0, "wr_byte");
    idle(5, 0, "rd_merged");
    #2 chk("spot_merge", "R_Data_A", R_Data_A, 32'hDEADBEAA);

    // Entry 0 is hardwired to zero, no drop pulse
    step(0, 5, 1'b1, 0, 32'h12345678, 4'b1111, 1'b0, 1'b0, "wr_zero");
    idle(0, 0, "rd_zero");
    #2 chk("spot_zero", "R_Data_A", R_Data_A, '0);
    chk("spot_zero", "W_Drop", DW'(W_Drop), '0);

    // Same-cycle partial write to a watched address
    step(0, 7, 1'b1, 7, 32'hAABBCCDD, 4'b1111, 1'b0, 1'b0, "wr7");
    step(0, 7, 1'b1, 7, 32'h11223344, 4'b0011, 1'b0, 1'b0, "bypass");
`ifdef REGFILE_BYPASS_EN
    #2 chk("spot_bypass", "R_Data_B", R_Data_B, 32'hAABB3344);
`else
    #2 chk("spot_bypass", "R_Data_B", R_Data_B, 32'hAABBCCDD);
`endif
    idle(0, 7, "after_bypass");
    #2 chk("spot_after_bypass", "R_Data_B", R_Data_B, 32'hAABB3344);

    // Fill, sweep with CLR_Req held, one dropped write mid-sweep
    for (int a = 1; a < int'(DEPTH); a++)
      step(AW'(a - 1), 0, 1'b1, AW'(a), DW'(a), 4'b1111, 1'b0, 1'b0, "fill");
    step(1, 31, 1'b0, '0, '0, '0, 1'b1, 1'b0, "clr_req");
    for (int k = 0; k < int'(DEPTH); k++) begin
      step((k > 0) ? AW'(k - 1) : AW'(0), AW'(k), (k == 5), 3, 32'h55,
           4'b1111, 1'b1, 1'b0, "sweep");
      if (k == 10) begin
        #2 chk("spot_sweep", "R_Data_A", R_Data_A, '0);
        chk("spot_sweep", "R_Data_B", R_Data_B, 32'd10);
        chk("spot_sweep", "Busy", DW'(Busy), 32'd1);
      end
      if (k == 6) begin
        #2 chk("spot_drop", "W_Drop", DW'(W_Drop), 32'd1);
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) idle(AW'(i), AW'(3), "post_sweep");
    #2 chk("spot_post", "Busy", DW'(Busy), '0);
    chk("spot_post", "R_Data_B", R_Data_B, '0);

    // Reset in the middle of a sweep
    step(0, 0, 1'b1, 20, 32'hCAFEF00D, 4'b1111, 1'b0, 1'b0, "pre_rst_wr");
    step(20, 0, 1'b0, '0, '0, '0, 1'b1, 1'b0, "pre_rst_clr");
    for (int k = 0; k < 10; k++) idle(20, AW'(k), "sweep_b");
    step(20, 20, 1'b0, '0, '0, '0, 1'b0, 1'b1, "rst_mid");
    #2 chk("spot_rst_mid", "Busy", DW'(Busy), '0);
    chk("spot_rst_mid", "R_Data_A", R_Data_A, '0);
    step(20, 2, 1'b0, '0, '0, '0, 1'b0, 1'b1, "rst_hold");
    step(2, 2, 1'b1, 2, 32'h77, 4'b1111, 1'b0, 1'b0, "wr_after_rst");
    idle(2, 2, "rd_after_rst");
    #2 chk("spot_after_rst", "R_Data_A", R_Data_A, 32'h77);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      step(AW'($urandom), AW'($urandom), 1'($urandom), AW'($urandom),
           DW'($urandom), NB'($urandom), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 199) == 0), "random");
    end

    // Let the monitor drain, bounded
    for (int w = 0; w < 4 && q.size() > 0; w++) begin
      @(posedge CLK);
      #3;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
